// File: rtl/panel_pkg.sv
// Shared constants and types for the KA10 front-panel key sequencer.
package panel_pkg;

    localparam logic [3:0] KEY_DEP_NXT = 4'd0;
    localparam logic [3:0] KEY_DEP     = 4'd1;
    localparam logic [3:0] KEY_EX_NXT  = 4'd2;
    localparam logic [3:0] KEY_EXA     = 4'd3;
    localparam logic [3:0] KEY_EXE     = 4'd4;
    localparam logic [3:0] KEY_RESET   = 4'd5;
    localparam logic [3:0] KEY_STOP    = 4'd6;
    localparam logic [3:0] KEY_CONT    = 4'd7;
    localparam logic [3:0] KEY_STA     = 4'd8;
    localparam logic [3:0] KEY_RDI     = 4'd9;

    localparam logic [1:0] REG_DSH = 2'd0;
    localparam logic [1:0] REG_DSL = 2'd1;
    localparam logic [1:0] REG_CMD = 2'd2;
    localparam logic [1:0] REG_CLR = 2'd3;

    localparam int CMD_W = 59;
    localparam int CNT_W = 21;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAITH = 3'd1,
        ST_SETUP = 3'd2,
        ST_PRESS = 3'd3,
        ST_GAPW  = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic        wait_halt;
        logic [3:0]  code;
        logic [17:0] addr;
        logic [35:0] ds;
    } cmd_t;

    function automatic logic code_valid(input logic [3:0] code);
        return code <= KEY_RDI;
    endfunction

endpackage

// File: rtl/panel_cmd_fifo.sv
// Command queue between the Avalon slave and the key sequencer; the oldest
// entry is always presented on dout.
module panel_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int CMD_W = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [CMD_W-1:0] din,
    input  logic             pop,
    output logic [CMD_W-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/panel_keyseq.sv
// Operator-panel key sequencer: queues AS/DS/key commands written over Avalon
// and plays each one out as a single timed momentary key press.
module panel_keyseq
    import panel_pkg::*;
#(
    parameter int SETUP   = 4,
    parameter int HOLD    = 16,
    parameter int GAP     = 16,
    parameter int TIMEOUT = 1048576,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   s_address,
    input  logic         s_write,
    input  logic         s_read,
    input  logic [31:0]  s_writedata,
    output logic [31:0]  s_readdata,
    output logic         s_waitrequest,
    input  logic         ind_run,
    output logic [9:0]   keys,
    output logic [0:35]  ds,
    output logic [18:35] as,
    output logic         busy
);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TIMEOUT - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       cur_code;
    logic [0:35]      staged_ds;
    logic             err, tmo, ovf;
    logic             cmd_wr, clr_wr, cmd_ok, cnt_zero, tmo_evt;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_W-1:0] fifo_din, fifo_dout;
    cmd_t             head;
    logic             unused_sigs;

    assign s_waitrequest = 1'b0;
    assign cmd_wr    = s_write && (s_address == REG_CMD);
    assign clr_wr    = s_write && (s_address == REG_CLR);
    assign cmd_ok    = code_valid(s_writedata[21:18]);
    assign fifo_push = cmd_wr && cmd_ok && !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign fifo_din  = {s_writedata[22:0], staged_ds};
    assign head      = cmd_t'(fifo_dout);
    assign cnt_zero  = (cnt == '0);
    assign tmo_evt   = (state == ST_WAITH) && ind_run && cnt_zero;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    assign keys      = (state == ST_PRESS) ? (10'd1 << cur_code) : 10'd0;
    assign unused_sigs = ^{s_read, s_writedata[31:23]};

    panel_cmd_fifo #(.DEPTH(DEPTH), .CMD_W(CMD_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            staged_ds <= '0;
        end else if (s_write && s_address == REG_DSH) begin
            staged_ds[0:17] <= s_writedata[17:0];
        end else if (s_write && s_address == REG_DSL) begin
            staged_ds[18:35] <= s_writedata[17:0];
        end
    end

    // A flag raised in the same cycle as its clear stays raised.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
            tmo <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (clr_wr && s_writedata[4]) ovf <= 1'b0;
            if (clr_wr && s_writedata[5]) tmo <= 1'b0;
            if (clr_wr && s_writedata[6]) err <= 1'b0;
            if (cmd_wr && !cmd_ok) err <= 1'b1;
            if (cmd_wr && cmd_ok && fifo_full) ovf <= 1'b1;
            if (tmo_evt) tmo <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cur_code <= '0;
            as       <= '0;
            ds       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        as       <= head.addr;
                        ds       <= head.ds;
                        cur_code <= head.code;
                        if (head.wait_halt) begin
                            state <= ST_WAITH;
                            cnt   <= TMO_LD;
                        end else begin
                            state <= ST_SETUP;
                            cnt   <= SETUP_LD;
                        end
                    end
                end
                ST_WAITH: begin
                    if (!ind_run) begin
                        state <= ST_SETUP;
                        cnt   <= SETUP_LD;
                    end else if (cnt_zero) begin
                        state <= ST_GAPW;
                        cnt   <= GAP_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_SETUP: begin
                    if (cnt_zero) begin
                        state <= ST_PRESS;
                        cnt   <= HOLD_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_PRESS: begin
                    if (cnt_zero) begin
                        state <= ST_GAPW;
                        cnt   <= GAP_LD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_GAPW: begin
                    if (cnt_zero) state <= ST_IDLE;
                    else          cnt   <= cnt - CNT_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_readdata = '0;
        case (s_address)
            REG_DSH: s_readdata[17:0] = staged_ds[0:17];
            REG_DSL: s_readdata[17:0] = staged_ds[18:35];
            REG_CMD: s_readdata[6:0]  = {err, tmo, ovf, fifo_full, fifo_empty, busy, ind_run};
            default: s_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_panel_keyseq.sv
// Bench for panel_keyseq: records every key pulse and compares it with
// commands and timings derived from the sequencing rules.
module tb_panel_keyseq;
    import panel_pkg::*;

    localparam int SETUP   = 4;
    localparam int HOLD    = 16;
    localparam int GAP     = 16;
    localparam int TIMEOUT = 100;
    localparam int DEPTH   = 4;
    localparam int SPACING = 1 + SETUP + HOLD + GAP;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   s_address = '0;
    logic         s_write = 1'b0;
    logic         s_read = 1'b0;
    logic [31:0]  s_writedata = '0;
    logic [31:0]  s_readdata;
    logic         s_waitrequest;
    logic         ind_run = 1'b0;
    logic [9:0]   keys;
    logic [0:35]  ds;
    logic [18:35] as;
    logic         busy;

    int compared = 0;
    int mismatched = 0;

    panel_keyseq #(.SETUP(SETUP), .HOLD(HOLD), .GAP(GAP), .TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .s_address(s_address), .s_write(s_write), .s_read(s_read),
        .s_writedata(s_writedata), .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .ind_run(ind_run), .keys(keys), .ds(ds), .as(as), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          code;
        logic [17:0] a;
        logic [35:0] d;
        int          rise;
        int          fall;
    } pulse_t;

    pulse_t pulses[$];
    pulse_t cur;
    bit     in_press = 1'b0;
    int     ncyc = 0;
    int     bad_onehot = 0;
    int     glitch = 0;

    // Pulse recorder: one entry per key press, timed in falling-edge counts.
    always @(negedge clk) begin
        ncyc++;
        if ((keys & (keys - 10'd1)) != 10'd0) bad_onehot++;
        if (!in_press) begin
            if (keys != 10'd0) begin
                in_press = 1'b1;
                cur.code = 0;
                for (int b = 0; b < 10; b++) if (keys[b]) cur.code = b;
                cur.a = as; cur.d = ds; cur.rise = ncyc; cur.fall = 0;
            end
        end else if (keys == 10'd0) begin
            cur.fall = ncyc;
            pulses.push_back(cur);
            in_press = 1'b0;
        end else if (keys !== (10'd1 << cur.code) || as !== cur.a || ds !== cur.d) begin
            glitch++;
        end
    end

    function automatic logic [31:0] cmd_word(input bit wh, input int code, input logic [17:0] a);
        return {9'd0, wh, 4'(code), a};
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        s_address = a; s_writedata = d; s_write = 1'b1;
        @(negedge clk); #1;
        s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a; s_read = 1'b1;
        #1 d = s_readdata;
        s_read = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget, output bit ok);
        int k = 0;
        while (pulses.size() < n && k < budget) begin @(negedge clk); #1; k++; end
        ok = (pulses.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int k = 0;
        while (busy !== 1'b0 && k < budget) begin @(negedge clk); #1; k++; end
        ok = (busy === 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        compared++;
        if (keys !== 10'd0 || as !== 18'd0 || ds !== 36'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs keys=%h as=%o ds=%o busy=%b required all zero", keys, as, ds, busy);
        end
        reset = 1'b1;
        wait_cycles(2);
        bus_read(REG_CMD, r);
        compared++;
        if (r !== 32'h4) begin mismatched++; $display("FAIL reset_status got=%h want=%h", r, 32'h4); end
        bus_read(REG_DSH, r);
        compared++;
        if (r !== 32'h0) begin mismatched++; $display("FAIL reset_dsh got=%h want=0", r); end
        compared++;
        if (s_waitrequest !== 1'b0) begin mismatched++; $display("FAIL waitrequest got=%b want=0", s_waitrequest); end
    endtask

    task automatic test_basic();
        logic [31:0] r; bit ok; int n0; pulse_t p;
        bus_write(REG_DSH, 32'o123456);
        bus_write(REG_DSL, 32'o654321);
        bus_read(REG_DSH, r);
        compared++;
        if (r !== 32'o123456) begin mismatched++; $display("FAIL dsh_readback got=%o want=%o", r, 32'o123456); end
        bus_read(REG_DSL, r);
        compared++;
        if (r !== 32'o654321) begin mismatched++; $display("FAIL dsl_readback got=%o want=%o", r, 32'o654321); end
        n0 = ncyc;
        bus_write(REG_CMD, cmd_word(1'b0, 1, 18'o1000));
        wait_pulses(1, 100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL basic_pulse got=none want=one pulse"); end
        else begin
            p = pulses.pop_front();
            compared++;
            if (p.code != 1 || p.a !== 18'o1000 || p.d !== 36'o123456654321) begin
                mismatched++;
                $display("FAIL basic_fields got code=%0d as=%o ds=%o want code=1 as=1000 ds=123456654321", p.code, p.a, p.d);
            end
            compared++;
            if (p.rise != n0 + 2 + SETUP || p.fall - p.rise != HOLD) begin
                mismatched++;
                $display("FAIL basic_timing got rise=%0d len=%0d want rise=%0d len=%0d", p.rise, p.fall - p.rise, n0 + 2 + SETUP, HOLD);
            end
        end
        wait_idle(100, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL basic_idle got busy=%b want 0", busy); end
    endtask

    task automatic test_error_code(input int code);
        logic [31:0] r;
        bus_write(REG_CMD, cmd_word(1'b0, code, 18'o17));
        wait_cycles(SPACING);
        bus_read(REG_CMD, r);
        compared++;
        if (pulses.size() != 0 || r[6] !== 1'b1 || r[2] !== 1'b1) begin
            mismatched++;
            $display("FAIL err_code%0d got pulses=%0d err=%b empty=%b want 0/1/1", code, pulses.size(), r[6], r[2]);
        end
        bus_write(REG_CLR, 32'h40);
        bus_read(REG_CMD, r);
        compared++;
        if (r[6] !== 1'b0) begin mismatched++; $display("FAIL err_clear got=%b want=0", r[6]); end
        pulses.delete();
    endtask

    task automatic test_random_single(input int iters);
        bit ok; int n0; int code; logic [17:0] a, dh, dl; pulse_t p;
        for (int it = 0; it < iters; it++) begin
            code = int'($urandom_range(0, 15));
            a = 18'($urandom); dh = 18'($urandom); dl = 18'($urandom);
            bus_write(REG_DSH, {14'd0, dh});
            bus_write(REG_DSL, {14'd0, dl});
            if (code > 9) begin
                test_error_code(code);
            end else begin
                n0 = ncyc;
                bus_write(REG_CMD, cmd_word(1'b0, code, a));
                wait_pulses(1, 100, ok);
                compared++;
                if (!ok) begin mismatched++; $display("FAIL rand_pulse it=%0d got=none want=one", it); end
                else begin
                    p = pulses.pop_front();
                    compared++;
                    if (p.code != code || p.a !== a || p.d !== {dh, dl} || p.rise != n0 + 2 + SETUP || p.fall - p.rise != HOLD) begin
                        mismatched++;
                        $display("FAIL rand_cmd it=%0d got code=%0d as=%o ds=%o rise=%0d len=%0d want code=%0d as=%o ds=%o rise=%0d len=%0d",
                                 it, p.code, p.a, p.d, p.rise, p.fall - p.rise, code, a, {dh, dl}, n0 + 2 + SETUP, HOLD);
                    end
                end
                wait_idle(100, ok);
            end
        end
    endtask

    task automatic test_back_to_back(input int k, input bit fixed_codes);
        logic [31:0] r; bit ok; int n0; int codes[$]; logic [17:0] addrs[$]; pulse_t p;
        bus_write(REG_DSH, 32'o707070);
        bus_write(REG_DSL, 32'o070707);
        for (int i = 0; i < k; i++) begin
            codes.push_back(fixed_codes ? (i == 0 ? 6 : 8) : int'($urandom_range(0, 9)));
            addrs.push_back(18'($urandom));
        end
        n0 = ncyc;
        for (int i = 0; i < k; i++) bus_write(REG_CMD, cmd_word(1'b0, codes[i], addrs[i]));
        bus_read(REG_CMD, r);
        compared++;
        if (r[4] !== 1'b0) begin mismatched++; $display("FAIL b2b_ovf got=%b want=0", r[4]); end
        wait_pulses(k, k * SPACING + 50, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL b2b_count got=%0d want=%0d", pulses.size(), k); end
        for (int i = 0; i < k && i < pulses.size(); i++) begin
            p = pulses[i];
            compared++;
            if (p.code != codes[i] || p.a !== addrs[i] || p.rise != n0 + 2 + SETUP + i * SPACING || p.fall - p.rise != HOLD) begin
                mismatched++;
                $display("FAIL b2b_cmd%0d got code=%0d as=%o rise=%0d len=%0d want code=%0d as=%o rise=%0d len=%0d",
                         i, p.code, p.a, p.rise, p.fall - p.rise, codes[i], addrs[i], n0 + 2 + SETUP + i * SPACING, HOLD);
            end
            if (fixed_codes && i > 0) begin
                compared++;
                if (p.rise - pulses[i-1].fall != GAP + 1 + SETUP) begin
                    mismatched++;
                    $display("FAIL gap_fall_to_rise got=%0d want=%0d", p.rise - pulses[i-1].fall, GAP + 1 + SETUP);
                end
            end
        end
        wait_idle(100, ok);
        pulses.delete();
    endtask

    task automatic test_overflow();
        logic [31:0] r; bit ok; int n1; int codes[5]; logic [17:0] addrs[5]; pulse_t p;
        ind_run = 1'b1;
        codes[0] = 7; addrs[0] = 18'($urandom);
        bus_write(REG_CMD, cmd_word(1'b1, codes[0], addrs[0]));
        for (int i = 1; i < 5; i++) begin
            codes[i] = int'($urandom_range(0, 9)); addrs[i] = 18'($urandom);
            bus_write(REG_CMD, cmd_word(1'b0, codes[i], addrs[i]));
        end
        bus_read(REG_CMD, r);
        compared++;
        if (r[3] !== 1'b1 || r[4] !== 1'b0 || r[1] !== 1'b1) begin
            mismatched++; $display("FAIL ovf_full got full=%b ovf=%b busy=%b want 1/0/1", r[3], r[4], r[1]);
        end
        bus_write(REG_CMD, cmd_word(1'b0, 2, 18'o7));
        bus_read(REG_CMD, r);
        compared++;
        if (r[4] !== 1'b1) begin mismatched++; $display("FAIL ovf_set got=%b want=1", r[4]); end
        n1 = ncyc;
        ind_run = 1'b0;
        wait_pulses(5, 5 * SPACING + 50, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL ovf_count got=%0d want=5", pulses.size()); end
        for (int i = 0; i < 5 && i < pulses.size(); i++) begin
            p = pulses[i];
            compared++;
            if (p.code != codes[i] || p.a !== addrs[i] || p.rise != n1 + 1 + SETUP + i * SPACING) begin
                mismatched++;
                $display("FAIL ovf_order%0d got code=%0d as=%o rise=%0d want code=%0d as=%o rise=%0d",
                         i, p.code, p.a, p.rise, codes[i], addrs[i], n1 + 1 + SETUP + i * SPACING);
            end
        end
        wait_cycles(SPACING + 10);
        compared++;
        if (pulses.size() != 5) begin mismatched++; $display("FAIL ovf_dropped got=%0d pulses want=5", pulses.size()); end
        bus_write(REG_CLR, 32'h10);
        bus_read(REG_CMD, r);
        compared++;
        if (r[4] !== 1'b0) begin mismatched++; $display("FAIL ovf_clear got=%b want=0", r[4]); end
        pulses.delete();
    endtask

    task automatic test_timeout();
        logic [31:0] r; bit ok; int n0; pulse_t p;
        ind_run = 1'b1;
        n0 = ncyc;
        bus_write(REG_CMD, cmd_word(1'b1, 3, 18'o11));
        bus_write(REG_CMD, cmd_word(1'b0, 5, 18'o22));
        wait_pulses(1, TIMEOUT + SPACING + GAP + 50, ok);
        compared++;
        if (!ok) begin mismatched++; $display("FAIL tmo_pulse got=none want=one"); end
        else begin
            p = pulses.pop_front();
            compared++;
            if (p.code != 5 || p.a !== 18'o22 || p.rise != n0 + 1 + (1 + TIMEOUT + GAP + 1 + SETUP)) begin
                mismatched++;
                $display("FAIL tmo_next got code=%0d as=%o rise=%0d want code=5 as=22 rise=%0d",
                         p.code, p.a, p.rise, n0 + 1 + (1 + TIMEOUT + GAP + 1 + SETUP));
            end
        end
        bus_read(REG_CMD, r);
        compared++;
        if (r[5] !== 1'b1) begin mismatched++; $display("FAIL tmo_set got=%b want=1", r[5]); end
        bus_write(REG_CLR, 32'h20);
        bus_read(REG_CMD, r);
        compared++;
        if (r[5] !== 1'b0) begin mismatched++; $display("FAIL tmo_clear got=%b want=0", r[5]); end
        ind_run = 1'b0;
        wait_idle(100, ok);
        pulses.delete();
    endtask

    task automatic test_async_reset();
        logic [31:0] r; int k;
        bus_write(REG_DSH, 32'o111111);
        bus_write(REG_DSL, 32'o222222);
        bus_write(REG_CMD, cmd_word(1'b0, 9, 18'o777));
        bus_write(REG_CMD, cmd_word(1'b0, 4, 18'o555));
        k = 0;
        while (keys == 10'd0 && k < 50) begin @(negedge clk); #1; k++; end
        wait_cycles(3);
        compared++;
        if (keys !== 10'b10_0000_0000) begin mismatched++; $display("FAIL rst_press got=%b want=1000000000", keys); end
        #2 reset = 1'b0;
        #1;
        compared++;
        if (keys !== 10'd0 || as !== 18'd0 || ds !== 36'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_async keys=%h as=%o ds=%o busy=%b required all zero", keys, as, ds, busy);
        end
        wait_cycles(2);
        reset = 1'b1;
        pulses.delete();
        bus_read(REG_CMD, r);
        compared++;
        if (r !== 32'h4) begin mismatched++; $display("FAIL rst_status got=%h want=%h", r, 32'h4); end
        bus_read(REG_DSL, r);
        compared++;
        if (r !== 32'h0) begin mismatched++; $display("FAIL rst_staged got=%h want=0", r); end
        wait_cycles(2 * SPACING);
        compared++;
        if (pulses.size() != 0) begin mismatched++; $display("FAIL rst_fifo_empty got=%0d pulses want=0", pulses.size()); end
    endtask

    task automatic test_invariants();
        compared++;
        if (bad_onehot != 0) begin mismatched++; $display("FAIL onehot got=%0d violations want=0", bad_onehot); end
        compared++;
        if (glitch != 0) begin mismatched++; $display("FAIL press_stable got=%0d changes want=0", glitch); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk); #1;
        test_reset();
        test_basic();
        test_error_code(12);
        test_random_single(8);
        test_back_to_back(5, 1'b0);
        test_back_to_back(int'($urandom_range(2, 5)), 1'b0);
        test_back_to_back(2, 1'b1);
        test_overflow();
        test_timeout();
        test_async_reset();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
